// File: rtl/half_adder.sv
// Multi-lane half adder with combinational and registered results, plus a
// saturating counter of accepted samples that produced any carry.
module half_adder #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_comb,
  output logic [WIDTH-1:0] carry_comb,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  logic any_carry;
  logic cnt_inc;

  assign sum_comb   = a ^ b;
  assign carry_comb = a & b;
  assign any_carry  = |carry_comb;

  // Count only accepted samples with a carry, and stop at all-ones.
  assign cnt_inc = in_valid && any_carry && (carry_count != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_comb;
        carry <= carry_comb;
      end
    end
  end

  // Clear takes priority over a coincident counting event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_count <= '0;
    end else if (cnt_clr) begin
      carry_count <= '0;
    end else if (cnt_inc) begin
      carry_count <= carry_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Directed bench: three parameterisations of half_adder sharing one clock/reset.
module tb_half_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1, CNT_W=16
  logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0, clr1 = 1'b0;
  logic       s1, c1, sc1, cc1, ov1;
  logic [15:0] cnt1;
  // WIDTH=8, CNT_W=16
  logic [7:0] a8 = '0, b8 = '0;
  logic       v8 = 1'b0, clr8 = 1'b0;
  logic [7:0] s8, c8, sc8, cc8;
  logic       ov8;
  logic [15:0] cnt8;
  // WIDTH=1, CNT_W=4
  logic       a4 = 1'b0, b4 = 1'b0, v4 = 1'b0, clr4 = 1'b0;
  logic       s4, c4, sc4, cc4, ov4;
  logic [3:0] cnt4;

  half_adder #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .cnt_clr(clr1),
    .sum(s1), .carry(c1), .sum_comb(sc1), .carry_comb(cc1),
    .out_valid(ov1), .carry_count(cnt1));

  half_adder #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8), .cnt_clr(clr8),
    .sum(s8), .carry(c8), .sum_comb(sc8), .carry_comb(cc8),
    .out_valid(ov8), .carry_count(cnt8));

  half_adder #(.WIDTH(1), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4), .cnt_clr(clr4),
    .sum(s4), .carry(c4), .sum_comb(sc4), .carry_comb(cc4),
    .out_valid(ov4), .carry_count(cnt4));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] c;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl1[4];
  vec_t tbl8[6];
  int unsigned exp_cnt;

  initial begin
    // single-lane truth table (only bit 0 used)
    tbl1[0] = '{8'h0, 8'h0, 8'h0, 8'h0};
    tbl1[1] = '{8'h0, 8'h1, 8'h1, 8'h0};
    tbl1[2] = '{8'h1, 8'h0, 8'h1, 8'h0};
    tbl1[3] = '{8'h1, 8'h1, 8'h0, 8'h1};
    // eight-lane vectors, expected values worked by hand
    tbl8[0] = '{8'hF0, 8'h3C, 8'hCC, 8'h30};
    tbl8[1] = '{8'hFF, 8'h01, 8'hFE, 8'h01};
    tbl8[2] = '{8'hAA, 8'h55, 8'hFF, 8'h00};
    tbl8[3] = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl8[4] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
    tbl8[5] = '{8'h81, 8'h80, 8'h01, 8'h80};

    // reset state, asynchronous with no clock edge yet seen
    #3;
    chk("rst_sum8", s8, 8'h00);
    chk("rst_carry8", c8, 8'h00);
    chk("rst_ov8", ov8, 1'b0);
    chk("rst_cnt8", cnt8, 16'd0);
    chk("rst_cnt4", cnt4, 4'd0);
    #9 rst_n = 1'b1;

    // in_valid=0: combinational outputs follow, registered ones stay 0
    for (int i = 0; i < 4; i++) begin
      a1 = tbl1[i].a[0];
      b1 = tbl1[i].b[0];
      #1;
      chk("comb_sum1", sc1, tbl1[i].s[0]);
      chk("comb_carry1", cc1, tbl1[i].c[0]);
      tick();
      chk("idle_sum1", s1, 1'b0);
      chk("idle_carry1", c1, 1'b0);
      chk("idle_ov1", ov1, 1'b0);
    end
    chk("idle_cnt1", cnt1, 16'd0);

    // in_valid=1 back-to-back, one-cycle latency
    for (int i = 0; i < 4; i++) begin
      a1 = tbl1[i].a[0];
      b1 = tbl1[i].b[0];
      v1 = 1'b1;
      tick();
      chk("reg_sum1", s1, tbl1[i].s[0]);
      chk("reg_carry1", c1, tbl1[i].c[0]);
      chk("reg_ov1", ov1, 1'b1);
    end
    v1 = 1'b0;
    a1 = 1'b0;
    b1 = 1'b1;
    tick();
    chk("hold_ov1", ov1, 1'b0);
    chk("hold_sum1", s1, 1'b0);
    chk("hold_carry1", c1, 1'b1);
    chk("cnt1", cnt1, 16'd1);

    // eight independent lanes
    exp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      a8 = tbl8[i].a;
      b8 = tbl8[i].b;
      v8 = 1'b1;
      #1;
      chk("comb_sum8", sc8, tbl8[i].s);
      chk("comb_carry8", cc8, tbl8[i].c);
      tick();
      if (tbl8[i].c != 8'h00) exp_cnt++;
      chk("reg_sum8", s8, tbl8[i].s);
      chk("reg_carry8", c8, tbl8[i].c);
      chk("reg_ov8", ov8, 1'b1);
      chk("cnt8", cnt8, exp_cnt);
    end
    v8 = 1'b0;
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    chk("clr_cnt8", cnt8, 16'd0);
    chk("clr_ov8", ov8, 1'b0);

    // 4-bit counter saturates at 15
    a4 = 1'b1;
    b4 = 1'b1;
    v4 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("sat_cnt4", cnt4, (i > 15) ? 15 : i);
    end
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    v4 = 1'b0;
    chk("clr_wins_cnt4", cnt4, 4'd0);
    chk("clr_ov4", ov4, 1'b1);

    // asynchronous reset mid-cycle with a sample in flight
    a8 = 8'hFF;
    b8 = 8'hFF;
    v8 = 1'b1;
    tick();
    chk("pre_rst_carry8", c8, 8'hFF);
    chk("pre_rst_cnt8", cnt8, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum8", s8, 8'h00);
    chk("arst_carry8", c8, 8'h00);
    chk("arst_ov8", ov8, 1'b0);
    chk("arst_cnt8", cnt8, 16'd0);
    a8 = 8'h0F;
    b8 = 8'hF3;
    #1;
    chk("arst_comb_sum8", sc8, 8'hFC);
    chk("arst_comb_carry8", cc8, 8'h03);
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    chk("rst_hold_ov8", ov8, 1'b0);
    chk("rst_hold_carry8", c8, 8'h00);
    chk("rst_hold_cnt8", cnt8, 16'd0);
    v8 = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ov8", ov8, 1'b0);
    chk("post_rst_sum8", s8, 8'h00);
    v8 = 1'b1;
    tick();
    v8 = 1'b0;
    chk("post_rst_ov8_new", ov8, 1'b1);
    chk("post_rst_sum8_new", s8, 8'hFC);
    chk("post_rst_carry8_new", c8, 8'h03);
    chk("post_rst_cnt8", cnt8, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1, number of independent bit-lanes, each a half adder; legal range 1..32.
REQ-002 Parameter CNT_W, default 16, width of the carry-event counter; legal range 4..32.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 Port a, input, WIDTH, operand A, one bit per lane.
REQ-006 Port b, input, WIDTH, operand B, one bit per lane.
REQ-007 Port in_valid, input, 1, a and b are sampled this cycle when high.
REQ-008 Port cnt_clr, input, 1, synchronous clear of carry_count.
REQ-009 Port sum, output, WIDTH, registered per-lane sum.
REQ-010 Port carry, output, WIDTH, registered per-lane carry.
REQ-011 Port sum_comb, output, WIDTH, combinational per-lane sum (a XOR b), no clock dependence.
REQ-012 Port carry_comb, output, WIDTH, combinational per-lane carry (a AND b), no clock dependence.
REQ-013 Port out_valid, output, 1, sum/carry hold a new result this cycle.
REQ-014 Port carry_count, output, CNT_W, saturating count of accepted samples with any carry bit set.

Function
REQ-015 Each lane i SHALL compute sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i]; lanes SHALL not interact.
REQ-016 sum_comb and carry_comb SHALL follow a/b combinationally with zero latency, independent of in_valid, clk and rst_n.
REQ-017 When in_valid=1 at a rising edge, sum and carry SHALL load the lane results at that edge (latency 1 cycle) and out_valid SHALL be 1 the following cycle.
REQ-018 When in_valid=0 at a rising edge, sum and carry SHALL hold their previous values and out_valid SHALL be 0 the following cycle.
REQ-019 No backpressure: every in_valid=1 cycle SHALL be accepted; back-to-back samples produce back-to-back out_valid pulses.
REQ-020 carry_count SHALL increment by 1 on each accepted sample where carry result is non-zero (reduction-OR of a AND b).
REQ-021 carry_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 cnt_clr=1 SHALL set carry_count to 0 at the edge; if a counting event coincides, clear wins (result 0).
REQ-023 Per lane, the 2-bit value {carry,sum} SHALL equal a[i]+b[i] (range 0..2).

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock, force sum=0, carry=0, out_valid=0, carry_count=0.
REQ-025 While rst_n=0, in_valid and cnt_clr SHALL be ignored; combinational outputs SHALL keep following a/b.
REQ-026 A sample in flight when reset asserts SHALL be discarded; first out_valid after release requires a new in_valid at an edge after rst_n returns high.

Verification
REQ-027 WIDTH=1, in_valid=1, (a,b) = 00,01,10,11 on successive cycles -> one cycle later (sum,carry) = (0,0),(1,0),(1,0),(0,1), out_valid=1 each cycle, carry_count=1.
REQ-028 Same four vectors with in_valid=0 -> sum_comb/carry_comb match table immediately; registered sum/carry stay 0, out_valid=0.
REQ-029 WIDTH=8, a=8'hF0, b=8'h3C, in_valid=1 -> next cycle sum=8'hCC, carry=8'h30, carry_count increments by 1.
REQ-030 CNT_W=4, 20 consecutive samples a=b=1 -> carry_count reaches 15 and holds; cnt_clr=1 together with an a=b=1 sample -> carry_count=0.
REQ-031 Drive rst_n low mid-stream between clock edges -> sum, carry, out_valid, carry_count go to 0 before the next edge; after release, out_valid stays 0 until a new in_valid sample.
